fm_ult_framer: RTL and testbench



---
 rtl/fm_sb_pkg.sv | 35 +++
 rtl/fm_ult_framer_if.sv | 31 +++
 rtl/fm_framer_fifo.sv | 56 +++++
 rtl/fm_ult_framer.sv | 169 ++++++++++++++++
 tb/tb_fm_ult_framer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fm_sb_pkg.sv
// Shared types and constants for the fast-monitoring spy-buffer path.
//   fm_rt              framed word as seen by a spy-buffer input (64-bit build)
//   fm_framer_state_t  output state machine of fm_ult_framer
//   fm_hdr_word        48-bit header payload {marker, frame_cnt, sb_id}
//   fm_trl_word        48-bit trailer payload {marker, wcnt[14:0], ovf, frame_cnt}
package fm_sb_pkg;

  localparam int unsigned FM_DATA_WIDTH = 64;

  localparam logic [15:0] FM_HDR_MARKER = 16'hFA57;
  localparam logic [15:0] FM_TRL_MARKER = 16'hE0F0;

  typedef struct packed {
    logic [FM_DATA_WIDTH-1:0] fm_data;
    logic                     fm_vld;
  } fm_rt;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPayload,
    StTrl
  } fm_framer_state_t;

  function automatic logic [47:0] fm_hdr_word(logic [15:0] frame_cnt, logic [15:0] sb_id);
    return {FM_HDR_MARKER, frame_cnt, sb_id};
  endfunction

  // Only the low 15 bits of the word count fit next to the overflow flag.
  function automatic logic [47:0] fm_trl_word(logic [15:0] wcnt, logic ovf,
                                              logic [15:0] frame_cnt);
    return {FM_TRL_MARKER, wcnt[14:0], ovf, frame_cnt};
  endfunction

endpackage

// File: rtl/fm_ult_framer_if.sv
// Stream bundle between a raw monitoring source, the framer and the spy buffer.
//   enable, in_data, in_vld, flush : raw stream and control into the framer
//   fm_data, fm_vld                : framed output word (the fm_rt fields)
//   out_sof, out_eof               : header / trailer markers for the framed word
// master: the side that owns the raw stream and consumes framed words.
// slave : the framer itself.
interface fm_ult_framer_if #(
  parameter int unsigned DATA_WIDTH = 64
);

  logic                  enable;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_vld;
  logic                  flush;

  logic [DATA_WIDTH-1:0] fm_data;
  logic                  fm_vld;
  logic                  out_sof;
  logic                  out_eof;

  modport master (
    output enable, in_data, in_vld, flush,
    input  fm_data, fm_vld, out_sof, out_eof
  );

  modport slave (
    input  enable, in_data, in_vld, flush,
    output fm_data, fm_vld, out_sof, out_eof
  );

endinterface

// File: rtl/fm_framer_fifo.sv
// Synchronous show-ahead FIFO used as the framer input buffer.
//   clk_hs, rst_hs : clock, asynchronous active-low reset
//   wr_en, wr_data : push (ignored while full)
//   rd_en          : pop (ignored while empty); rd_data shows the head word
//   full, empty    : occupancy flags from registered pointers
// FIFO_DEPTH must be a power of 2 and at least 2.
module fm_framer_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk_hs,
  input  logic                  rst_hs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_hs or negedge rst_hs) begin
    if (!rst_hs) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_hs) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fm_ult_framer.sv
// Frames one raw monitoring stream into header / payload / trailer fm_rt words.
//   clk_hs, rst_hs : clock, asynchronous active-low reset
//   bus (slave)    : enable, in_data, in_vld, flush in; fm_data, fm_vld, out_sof, out_eof out
//   frame_cnt      : completed frames, wraps
//   drop_cnt       : words dropped on a full FIFO, saturates
// Build option FM_FRAMER_DROP_STATS_EN: when defined, drop_cnt counts and the trailer
// ovf bit reports drops within the frame; otherwise both read 0.
// DATA_WIDTH must be at least 48; FIFO_DEPTH a power of 2, at least 2.
module fm_ult_framer
  import fm_sb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] SB_ID      = 16'h0000
) (
  input  logic                clk_hs,
  input  logic                rst_hs,
  fm_ult_framer_if.slave      bus,
  output logic [15:0]         frame_cnt,
  output logic [31:0]         drop_cnt
);

  logic                  fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  drop;

  fm_framer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_hs  (clk_hs),
    .rst_hs  (rst_hs),
    .wr_en   (fifo_wr),
    .wr_data (bus.in_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Full is the pre-edge flag, so a same-cycle pop never rescues a write.
  assign fifo_wr = bus.in_vld && bus.enable && !fifo_full;
  assign drop    = bus.in_vld && bus.enable && fifo_full;

  fm_framer_state_t      state_q, state_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  flush_q, flush_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
  logic                  flush_pend, close;
  logic                  ovf;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    frame_cnt_d = frame_cnt_q;
    flush_d     = flush_q;
    data_d      = '0;
    vld_d       = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    fifo_rd     = 1'b0;
    close       = 1'b0;
    // A raw pulse counts immediately only once the frame is in its payload phase.
    flush_pend  = flush_q || (bus.flush && state_q == StPayload);

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          flush_d = flush_q || bus.flush;
          state_d = StHdr;
          wcnt_d  = '0;
          data_d  = DATA_WIDTH'(fm_hdr_word(frame_cnt_q, SB_ID));
          vld_d   = 1'b1;
          sof_d   = 1'b1;
        end
      end
      // The header is on the output during StHdr, so that cycle already pops payload.
      StHdr, StPayload: begin
        if (bus.flush && (state_q == StPayload || !fifo_empty)) flush_d = 1'b1;
        if (wcnt_q == 16'(FRAME_LEN) || (flush_pend && fifo_empty)) begin
          close   = 1'b1;
          flush_d = 1'b0;
          state_d = StTrl;
          data_d  = DATA_WIDTH'(fm_trl_word(wcnt_q, ovf, frame_cnt_q));
          vld_d   = 1'b1;
          eof_d   = 1'b1;
        end else begin
          state_d = StPayload;
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            data_d  = fifo_rd_data;
            vld_d   = 1'b1;
            wcnt_d  = wcnt_q + 16'd1;
          end
        end
      end
      StTrl: begin
        // Only a flush for a frame that is already queued survives the trailer.
        if (bus.flush && !fifo_empty) flush_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (close) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_hs or negedge rst_hs) begin
    if (!rst_hs) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      frame_cnt_q <= '0;
      flush_q     <= 1'b0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      frame_cnt_q <= frame_cnt_d;
      flush_q     <= flush_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

`ifdef FM_FRAMER_DROP_STATS_EN
  logic        ovf_q, ovf_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
    // A drop on the closing cycle belongs to the next frame.
    ovf_d = close ? drop : (ovf_q || drop);
  end

  always_ff @(posedge clk_hs or negedge rst_hs) begin
    if (!rst_hs) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign ovf         = 1'b0;
  assign drop_cnt    = '0;
`endif

  assign bus.fm_data = data_q;
  assign bus.fm_vld  = vld_q;
  assign bus.out_sof = sof_q;
  assign bus.out_eof = eof_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_fm_ult_framer.sv
// Directed bench for fm_ult_framer: FRAME_LEN=4, SB_ID=3, FIFO_DEPTH=8, 64-bit words.
module tb_fm_ult_framer;

  logic        clk_hs = 1'b0;
  logic        rst_hs = 1'b0;
  logic [15:0] frame_cnt;
  logic [31:0] drop_cnt;

  fm_ult_framer_if #(.DATA_WIDTH(64)) bus ();

  fm_ult_framer #(
    .DATA_WIDTH (64),
    .FRAME_LEN  (4),
    .FIFO_DEPTH (8),
    .SB_ID      (16'h0003)
  ) dut (
    .clk_hs    (clk_hs),
    .rst_hs    (rst_hs),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_hs = ~clk_hs;

  typedef struct {
    logic        sof;
    logic        eof;
    logic [63:0] data;
    int          cyc;
  } mon_t;

  mon_t mon_q[$];
  int   cyc      = 0;
  int   both_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk_hs) cyc <= cyc + 1;

  always @(negedge clk_hs) begin
    if (bus.fm_vld) begin
      mon_q.push_back('{sof: bus.out_sof, eof: bus.out_eof, data: bus.fm_data, cyc: cyc});
      if (bus.out_sof && bus.out_eof) both_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Missing entries read as sof=eof=1, which no legal word carries.
  function automatic logic [65:0] entry(input int idx);
    if (idx < mon_q.size()) return {mon_q[idx].sof, mon_q[idx].eof, mon_q[idx].data};
    return '1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk_hs);
    #1;
  endtask

  task automatic push_word(input logic [63:0] d);
    bus.in_vld  = 1'b1;
    bus.in_data = d;
    @(posedge clk_hs);
    #1;
    bus.in_vld  = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge clk_hs);
    #1;
    bus.flush = 1'b0;
  endtask

  localparam logic [1:0] HDR = 2'b10;
  localparam logic [1:0] PAY = 2'b00;
  localparam logic [1:0] TRL = 2'b01;

  int e0;
  int n_pay, n_trl, n_ovf, bad_order;
  logic [63:0] last_pay;

  initial begin
    bus.enable  = 1'b1;
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.flush   = 1'b0;

    // Reset state
    idle(3);
    check_eq("rst_data", 66'(bus.fm_data), 66'h0);
    check_eq("rst_vld", 66'(bus.fm_vld), 66'h0);
    check_eq("rst_sof", 66'(bus.out_sof), 66'h0);
    check_eq("rst_eof", 66'(bus.out_eof), 66'h0);
    check_eq("rst_frame_cnt", 66'(frame_cnt), 66'h0);
    check_eq("rst_drop_cnt", 66'(drop_cnt), 66'h0);
    rst_hs = 1'b1;
    idle(2);

    // Single full frame
    mon_q.delete();
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) push_word(64'h11 + 64'(i));
    idle(12);
    check_eq("t1_count", 66'(mon_q.size()), 66'd6);
    check_eq("t1_hdr", entry(0), {HDR, 64'h0000_FA57_0000_0003});
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t1_pay%0d", i), entry(i + 1), {PAY, 64'h11 + 64'(i)});
    check_eq("t1_trl", entry(5), {TRL, 64'h0000_E0F0_0008_0000});
    if (mon_q.size() >= 2) begin
      check_eq("t1_hdr_latency", 66'(mon_q[0].cyc), 66'(e0 + 1));
      check_eq("t1_pay_latency", 66'(mon_q[1].cyc), 66'(e0 + 2));
    end else begin
      check_eq("t1_latency_missing", 66'(mon_q.size()), 66'd2);
    end
    check_eq("t1_frame_cnt", 66'(frame_cnt), 66'd1);

    // Early close by flush
    mon_q.delete();
    push_word(64'h21);
    push_word(64'h22);
    pulse_flush();
    idle(20);
    check_eq("t2_count", 66'(mon_q.size()), 66'd4);
    check_eq("t2_hdr", entry(0), {HDR, 64'h0000_FA57_0001_0003});
    check_eq("t2_pay0", entry(1), {PAY, 64'h21});
    check_eq("t2_pay1", entry(2), {PAY, 64'h22});
    check_eq("t2_trl", entry(3), {TRL, 64'h0000_E0F0_0004_0001});
    check_eq("t2_frame_cnt", 66'(frame_cnt), 66'd2);

    // enable low blocks all writes
    mon_q.delete();
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) push_word(64'h40 + 64'(i));
    bus.enable = 1'b1;
    idle(20);
    check_eq("t3_no_output", 66'(mon_q.size()), 66'd0);
    check_eq("t3_drop_cnt", 66'(drop_cnt), 66'd0);
    check_eq("t3_frame_cnt", 66'(frame_cnt), 66'd2);

    // Overflow: 40 back-to-back words outrun the 4/7 drain rate; 10 are dropped
    mon_q.delete();
    for (int i = 0; i < 40; i++) push_word(64'h100 + 64'(i));
    idle(30);
    pulse_flush();
    idle(5);
    n_pay = 0; n_trl = 0; n_ovf = 0; bad_order = 0; last_pay = '0;
    foreach (mon_q[i]) begin
      if (!mon_q[i].sof && !mon_q[i].eof) begin
        if (n_pay > 0 && mon_q[i].data <= last_pay) bad_order++;
        last_pay = mon_q[i].data;
        n_pay++;
      end
      if (mon_q[i].eof) begin
        n_trl++;
        if (mon_q[i].data[16]) n_ovf++;
      end
    end
    check_eq("t4_hdr", entry(0), {HDR, 64'h0000_FA57_0002_0003});
    check_eq("t4_payloads", 66'(n_pay), 66'd30);
    check_eq("t4_order", 66'(bad_order), 66'd0);
    check_eq("t4_trailers", 66'(n_trl), 66'd8);
    check_eq("t4_last_trl", entry(mon_q.size() - 1), {TRL, 64'h0000_E0F0_0004_0009});
    check_eq("t4_frame_cnt", 66'(frame_cnt), 66'd10);
`ifdef FM_FRAMER_DROP_STATS_EN
    check_eq("t4_drop_cnt", 66'(drop_cnt), 66'd10);
    check_eq("t4_drop_vs_emitted", 66'(drop_cnt), 66'(40 - n_pay));
    check_eq("t4_ovf_trailers", 66'(n_ovf), 66'd4);
`else
    check_eq("t4_drop_cnt", 66'(drop_cnt), 66'd0);
    check_eq("t4_ovf_trailers", 66'(n_ovf), 66'd0);
`endif

    // Reset in the middle of a frame
    mon_q.delete();
    for (int i = 0; i < 4; i++) push_word(64'h51 + 64'(i));
    idle(1);
    check_eq("t5_pre_rst_pay", {bus.out_sof, bus.out_eof, bus.fm_data}, {PAY, 64'h53});
    #2;
    rst_hs = 1'b0;
    #1;
    check_eq("t5_async_data", 66'(bus.fm_data), 66'h0);
    check_eq("t5_async_vld", 66'(bus.fm_vld), 66'h0);
    check_eq("t5_async_sof_eof", 66'({bus.out_sof, bus.out_eof}), 66'h0);
    check_eq("t5_async_frame_cnt", 66'(frame_cnt), 66'h0);
    check_eq("t5_async_drop_cnt", 66'(drop_cnt), 66'h0);
    idle(2);
    rst_hs = 1'b1;
    idle(2);
    mon_q.delete();
    push_word(64'h61);
    pulse_flush();
    idle(10);
    check_eq("t5_count", 66'(mon_q.size()), 66'd3);
    check_eq("t5_hdr", entry(0), {HDR, 64'h0000_FA57_0000_0003});
    check_eq("t5_pay", entry(1), {PAY, 64'h61});
    check_eq("t5_trl", entry(2), {TRL, 64'h0000_E0F0_0002_0000});

    // frame_cnt wrap
    mon_q.delete();
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    idle(1);
    push_word(64'h71);
    pulse_flush();
    idle(10);
    check_eq("t6_hdr", entry(0), {HDR, 64'h0000_FA57_FFFF_0003});
    check_eq("t6_trl", entry(2), {TRL, 64'h0000_E0F0_0002_FFFF});
    check_eq("t6_frame_cnt", 66'(frame_cnt), 66'h0);

    check_eq("sof_eof_exclusive", 66'(both_cnt), 66'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
